// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch request sequencer.
//   fetch_state_e   : request FSM states
//   WORD_ALIGN_MASK : clears the byte offset of an address
//   ADDR_INCR       : stride between consecutive fetch words
package fetch_pkg;

   typedef enum logic [0:0] {
      IDLE     = 1'b0,
      REQ_WAIT = 1'b1
   } fetch_state_e;

   localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;
   localparam logic [31:0] ADDR_INCR       = 32'd4;

   function automatic logic [31:0] word_align(input logic [31:0] a);
      return a & WORD_ALIGN_MASK;
   endfunction

endpackage

// File: rtl/fetch_req_ctrl_if.sv
// Fetch sequencer bundle: control inputs from the pipeline, the instruction
// bus req/gnt/rvalid port and the prefetch FIFO strobes.
//   master : the sequencer (drives req/addr and FIFO strobes)
//   slave  : pipeline/bus/FIFO side
interface fetch_req_ctrl_if #(
   parameter int FIFO_DEPTH = 3
);
   localparam int FW = $clog2(FIFO_DEPTH + 1);

   logic          fetch_en_i;
   logic          redirect_i;
   logic [31:0]   redirect_addr_i;
   logic [FW-1:0] fifo_free_i;
   logic          instr_req_o;
   logic [31:0]   instr_addr_o;
   logic          instr_gnt_i;
   logic          instr_rvalid_i;
   logic          instr_err_i;
   logic          fifo_push_o;
   logic          fifo_err_o;
   logic          fifo_clear_o;
   logic          busy_o;

   modport master (
      input  fetch_en_i, redirect_i, redirect_addr_i, fifo_free_i,
             instr_gnt_i, instr_rvalid_i, instr_err_i,
      output instr_req_o, instr_addr_o, fifo_push_o, fifo_err_o,
             fifo_clear_o, busy_o
   );

   modport slave (
      output fetch_en_i, redirect_i, redirect_addr_i, fifo_free_i,
             instr_gnt_i, instr_rvalid_i, instr_err_i,
      input  instr_req_o, instr_addr_o, fifo_push_o, fifo_err_o,
             fifo_clear_o, busy_o
   );

endinterface

// File: rtl/fetch_txn_counter.sv
// Up/down counter with synchronous load, saturating at 0 and MAX.
//   clk, rst  : clock, async active-high reset (clears to 0)
//   inc, dec  : count up/down; both together hold the value
//   load      : overrides inc/dec with load_val (clamped to MAX)
//   cnt       : current count
module fetch_txn_counter #(
   parameter int MAX = 2,
   parameter int W   = $clog2(MAX + 1)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         dec,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic [W-1:0] cnt
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (load)
         cnt <= (load_val > W'(MAX)) ? W'(MAX) : load_val;
      else if (inc && !dec && cnt != W'(MAX))
         cnt <= cnt + W'(1);
      else if (dec && !inc && cnt != '0)
         cnt <= cnt - W'(1);
   end

endmodule

// File: rtl/fetch_req_ctrl.sv
// Instruction-bus request sequencer feeding the prefetch FIFO.
// Issues word-aligned fetches, keeps at most NUM_REQS transactions in flight
// (further bounded by free FIFO space), turns responses into FIFO pushes and
// drops responses belonging to requests issued before a redirect.
//   clk, rst : clock, async active-high reset
//   bus      : fetch_req_ctrl_if.master (control, instr bus, FIFO strobes)
module fetch_req_ctrl
   import fetch_pkg::*;
#(
   parameter logic [31:0] PC_RESET   = 32'h0,
   parameter int          NUM_REQS   = 2,
   parameter int          FIFO_DEPTH = 3
) (
   input  logic             clk,
   input  logic             rst,
   fetch_req_ctrl_if.master bus
);

   localparam int CW = $clog2(NUM_REQS + 1);
   localparam int FW = $clog2(FIFO_DEPTH + 1);

   fetch_state_e  state_q, state_d;
   logic [31:0]   fetch_addr_q, fetch_addr_d;
   logic [31:0]   req_addr_q, req_addr_d;
   logic          redir_pend_q, redir_pend_d;
   logic          err_hold_q, err_hold_d;
   logic [CW-1:0] out_cnt, disc_cnt, live_cnt, disc_load;
   logic [FW-1:0] free;
   logic          can_issue, gnt_acc, rsp_ok, push, disc_inc, disc_dec;

   // Responses still owed to requests issued after the last redirect; only
   // these will consume FIFO entries.
   assign live_cnt  = out_cnt - disc_cnt;
   assign free      = bus.fifo_free_i;
   assign can_issue = bus.fetch_en_i && !err_hold_q
                      && (32'(out_cnt) < 32'(NUM_REQS))
                      && (32'(live_cnt) < 32'(free));

   assign gnt_acc  = bus.instr_req_o && bus.instr_gnt_i;
   // rvalid with nothing outstanding is a bus error and is ignored
   assign rsp_ok   = bus.instr_rvalid_i && (out_cnt != '0);
   assign push     = rsp_ok && (disc_cnt == '0) && !bus.redirect_i;
   assign disc_dec = rsp_ok && (disc_cnt != '0);
   // Everything still in flight after this edge becomes stale on redirect
   assign disc_load = out_cnt + CW'(gnt_acc) - CW'(rsp_ok);

   assign bus.fifo_push_o  = push;
   assign bus.fifo_err_o   = push && bus.instr_err_i;
   assign bus.fifo_clear_o = bus.redirect_i;
   assign bus.busy_o       = (out_cnt != '0) || (state_q == REQ_WAIT);

   always_comb begin
      state_d          = state_q;
      fetch_addr_d     = fetch_addr_q;
      req_addr_d       = req_addr_q;
      redir_pend_d     = redir_pend_q;
      err_hold_d       = err_hold_q;
      disc_inc         = 1'b0;
      bus.instr_req_o  = 1'b0;
      bus.instr_addr_o = fetch_addr_q;

      case (state_q)
         IDLE: begin
            if (can_issue) begin
               bus.instr_req_o = 1'b1;
               if (bus.instr_gnt_i) begin
                  fetch_addr_d = fetch_addr_q + ADDR_INCR;
               end else begin
                  state_d    = REQ_WAIT;
                  req_addr_d = fetch_addr_q;
               end
            end
         end
         REQ_WAIT: begin
            // Held request is never retracted, whatever else happens
            bus.instr_req_o  = 1'b1;
            bus.instr_addr_o = req_addr_q;
            if (bus.instr_gnt_i) begin
               state_d = IDLE;
               if (redir_pend_q) begin
                  // Stale request: count it for discard, keep redirect target
                  disc_inc     = 1'b1;
                  redir_pend_d = 1'b0;
               end else begin
                  fetch_addr_d = req_addr_q + ADDR_INCR;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (push && bus.instr_err_i)
         err_hold_d = 1'b1;

      if (bus.redirect_i) begin
         fetch_addr_d = word_align(bus.redirect_addr_i);
         err_hold_d   = 1'b0;
         // Any request left hanging past this edge targets the old stream
         if (state_d == REQ_WAIT)
            redir_pend_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         fetch_addr_q <= word_align(PC_RESET);
         req_addr_q   <= word_align(PC_RESET);
         redir_pend_q <= 1'b0;
         err_hold_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         fetch_addr_q <= fetch_addr_d;
         req_addr_q   <= req_addr_d;
         redir_pend_q <= redir_pend_d;
         err_hold_q   <= err_hold_d;
      end
   end

   fetch_txn_counter #(.MAX(NUM_REQS), .W(CW)) u_out_cnt (
      .clk      (clk),
      .rst      (rst),
      .inc      (gnt_acc),
      .dec      (rsp_ok),
      .load     (1'b0),
      .load_val ('0),
      .cnt      (out_cnt)
   );

   fetch_txn_counter #(.MAX(NUM_REQS), .W(CW)) u_disc_cnt (
      .clk      (clk),
      .rst      (rst),
      .inc      (disc_inc),
      .dec      (disc_dec),
      .load     (bus.redirect_i),
      .load_val (disc_load),
      .cnt      (disc_cnt)
   );

   rvalid_needs_outstanding: assert property (
      @(posedge clk) disable iff (rst) !(bus.instr_rvalid_i && out_cnt == '0));

endmodule

// File: tb/tb_fetch_req_ctrl.sv
// Scoreboard bench for fetch_req_ctrl: stimulus pushes hand-computed request
// addresses and push results into queues; a negedge monitor pops and compares
// on every grant and every FIFO push. Response identity is tracked by a small
// bus model queue of granted addresses.
module tb_fetch_req_ctrl;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fetch_req_ctrl_if #(.FIFO_DEPTH(3)) bus ();

   fetch_req_ctrl #(
      .PC_RESET   (32'h100),
      .NUM_REQS   (2),
      .FIFO_DEPTH (3)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int errors = 0;
   int checks = 0;
   logic [31:0] exp_req[$];
   logic [31:0] exp_push_addr[$];
   logic        exp_push_err[$];
   logic [31:0] bus_q[$];
   logic [31:0] mon_rsp_addr;
   logic [31:0] mon_e_addr;
   logic        mon_e_err;
   bit          auto_rsp = 1'b0;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk1(string name, logic act, logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic chk_empty(string name);
      chk({name, "_req_left"}, 32'(exp_req.size()), 32'd0);
      chk({name, "_push_left"}, 32'(exp_push_addr.size()), 32'd0);
   endtask

   task automatic exp_both(logic [31:0] a);
      exp_req.push_back(a);
      exp_push_addr.push_back(a);
      exp_push_err.push_back(1'b0);
   endtask

   // One clock; in auto mode the bus answers every grant one cycle later.
   task automatic tick();
      logic g;
      @(negedge clk);
      g = bus.instr_req_o & bus.instr_gnt_i;
      @(posedge clk);
      #1;
      if (auto_rsp) bus.instr_rvalid_i = g;
   endtask

   // Monitor: pop the response first (it belongs to an older grant).
   always @(negedge clk) begin
      mon_rsp_addr = 32'hDEAD_BEEF;
      if (rst) begin
         bus_q.delete();
      end else begin
         if (bus.instr_rvalid_i && bus_q.size() > 0)
            mon_rsp_addr = bus_q.pop_front();
         if (bus.fifo_push_o) begin
            if (exp_push_addr.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_push: got push of %h expected none", mon_rsp_addr);
            end else begin
               mon_e_addr = exp_push_addr.pop_front();
               mon_e_err  = exp_push_err.pop_front();
               chk("push_addr", mon_rsp_addr, mon_e_addr);
               chk1("push_err", bus.fifo_err_o, mon_e_err);
            end
         end
         if (bus.instr_req_o && bus.instr_gnt_i) begin
            if (exp_req.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_grant: got addr %h expected none", bus.instr_addr_o);
            end else begin
               chk("req_addr", bus.instr_addr_o, exp_req.pop_front());
            end
            bus_q.push_back(bus.instr_addr_o);
         end
      end
   end

   initial begin
      rst                 = 1'b1;
      bus.fetch_en_i      = 1'b0;
      bus.redirect_i      = 1'b0;
      bus.redirect_addr_i = 32'h0;
      bus.fifo_free_i     = 2'd3;
      bus.instr_gnt_i     = 1'b0;
      bus.instr_rvalid_i  = 1'b0;
      bus.instr_err_i     = 1'b0;

      // reset values
      #1;
      chk1("rst_req", bus.instr_req_o, 1'b0);
      chk("rst_addr", bus.instr_addr_o, 32'h100);
      chk1("rst_push", bus.fifo_push_o, 1'b0);
      chk1("rst_err", bus.fifo_err_o, 1'b0);
      chk1("rst_busy", bus.busy_o, 1'b0);
      bus.redirect_i = 1'b1;
      #1;
      chk1("rst_clear_hi", bus.fifo_clear_o, 1'b1);
      bus.redirect_i = 1'b0;
      #1;
      chk1("rst_clear_lo", bus.fifo_clear_o, 1'b0);
      @(posedge clk);
      #1;

      // streaming: back-to-back grants, response one cycle after grant
      for (int i = 0; i < 6; i++) exp_both(32'h100 + 32'(4 * i));
      bus.fetch_en_i  = 1'b1;
      bus.instr_gnt_i = 1'b1;
      auto_rsp        = 1'b1;
      rst             = 1'b0;
      #1;
      chk1("first_req", bus.instr_req_o, 1'b1);
      repeat (6) tick();
      bus.fetch_en_i = 1'b0;
      tick();
      tick();
      auto_rsp = 1'b0;
      chk1("stream_idle_req", bus.instr_req_o, 1'b0);
      chk1("stream_idle_busy", bus.busy_o, 1'b0);
      chk_empty("stream");

      // outstanding limit
      exp_both(32'h118); exp_both(32'h11C); exp_both(32'h120);
      bus.fetch_en_i = 1'b1;
      tick();
      tick();
      chk1("limit_req_off0", bus.instr_req_o, 1'b0);
      chk1("limit_busy", bus.busy_o, 1'b1);
      tick();
      chk1("limit_req_off1", bus.instr_req_o, 1'b0);
      bus.instr_rvalid_i = 1'b1;
      tick();
      bus.instr_rvalid_i = 1'b0;
      chk1("limit_req_resume", bus.instr_req_o, 1'b1);
      tick();
      bus.fetch_en_i     = 1'b0;
      bus.instr_rvalid_i = 1'b1;
      tick();
      tick();
      bus.instr_rvalid_i = 1'b0;
      tick();
      chk_empty("limit");

      // free-space bound
      exp_both(32'h124); exp_both(32'h128); exp_both(32'h12C);
      bus.fetch_en_i = 1'b1;
      tick();
      tick();
      bus.fifo_free_i    = 2'd1;
      bus.instr_rvalid_i = 1'b1;
      tick();
      bus.instr_rvalid_i = 1'b0;
      chk1("free_block0", bus.instr_req_o, 1'b0);
      tick();
      chk1("free_block1", bus.instr_req_o, 1'b0);
      tick();
      chk1("free_block2", bus.instr_req_o, 1'b0);
      bus.instr_rvalid_i = 1'b1;
      tick();
      bus.instr_rvalid_i = 1'b0;
      chk1("free_resume", bus.instr_req_o, 1'b1);
      tick();
      chk1("free_block_after", bus.instr_req_o, 1'b0);
      bus.fetch_en_i     = 1'b0;
      bus.fifo_free_i    = 2'd3;
      bus.instr_rvalid_i = 1'b1;
      tick();
      bus.instr_rvalid_i = 1'b0;
      tick();
      chk_empty("free");

      // redirect with two in flight: both stale responses dropped
      exp_req.push_back(32'h130);
      exp_req.push_back(32'h134);
      exp_both(32'h200);
      bus.fetch_en_i = 1'b1;
      tick();
      tick();
      bus.redirect_i      = 1'b1;
      bus.redirect_addr_i = 32'h202;
      bus.fetch_en_i      = 1'b0;
      #1;
      chk1("redir_clear", bus.fifo_clear_o, 1'b1);
      chk1("redir_no_req", bus.instr_req_o, 1'b0);
      tick();
      bus.redirect_i     = 1'b0;
      bus.instr_rvalid_i = 1'b1;
      #1;
      chk("redir_target_addr", bus.instr_addr_o, 32'h200);
      chk1("redir_drop0", bus.fifo_push_o, 1'b0);
      tick();
      #1;
      chk1("redir_drop1", bus.fifo_push_o, 1'b0);
      tick();
      bus.instr_rvalid_i = 1'b0;
      bus.fetch_en_i     = 1'b1;
      tick();
      bus.fetch_en_i     = 1'b0;
      bus.instr_rvalid_i = 1'b1;
      tick();
      bus.instr_rvalid_i = 1'b0;
      tick();
      chk_empty("redir");

      // redirect while a request is held un-granted
      exp_req.push_back(32'h204);
      exp_both(32'h300);
      bus.instr_gnt_i = 1'b0;
      bus.fetch_en_i  = 1'b1;
      tick();
      bus.redirect_i      = 1'b1;
      bus.redirect_addr_i = 32'h300;
      #1;
      chk1("wait_req0", bus.instr_req_o, 1'b1);
      chk("wait_addr0", bus.instr_addr_o, 32'h204);
      chk1("wait_busy", bus.busy_o, 1'b1);
      tick();
      bus.redirect_i = 1'b0;
      bus.fetch_en_i = 1'b0;
      #1;
      chk1("wait_req1", bus.instr_req_o, 1'b1);
      chk("wait_addr1", bus.instr_addr_o, 32'h204);
      tick();
      bus.instr_gnt_i = 1'b1;
      bus.fetch_en_i  = 1'b1;
      tick();
      chk("wait_target_addr", bus.instr_addr_o, 32'h300);
      tick();
      bus.fetch_en_i     = 1'b0;
      bus.instr_rvalid_i = 1'b1;
      #1;
      chk1("wait_stale_drop", bus.fifo_push_o, 1'b0);
      tick();
      tick();
      bus.instr_rvalid_i = 1'b0;
      tick();
      chk_empty("wait");

      // error response holds off issue until redirect
      exp_req.push_back(32'h304);
      exp_push_addr.push_back(32'h304);
      exp_push_err.push_back(1'b1);
      exp_both(32'h308);
      exp_req.delete(1);
      exp_req.push_back(32'h308);
      exp_both(32'h400);
      exp_req.delete(2);
      exp_req.push_back(32'h400);
      bus.fetch_en_i = 1'b1;
      tick();
      tick();
      bus.instr_rvalid_i = 1'b1;
      bus.instr_err_i    = 1'b1;
      #1;
      chk1("err_push", bus.fifo_push_o, 1'b1);
      chk1("err_flag", bus.fifo_err_o, 1'b1);
      tick();
      bus.instr_err_i = 1'b0;
      tick();
      bus.instr_rvalid_i = 1'b0;
      chk1("err_hold_req0", bus.instr_req_o, 1'b0);
      tick();
      chk1("err_hold_req1", bus.instr_req_o, 1'b0);
      bus.redirect_i      = 1'b1;
      bus.redirect_addr_i = 32'h400;
      #1;
      chk1("err_redir_req", bus.instr_req_o, 1'b0);
      tick();
      bus.redirect_i = 1'b0;
      #1;
      chk1("err_resume", bus.instr_req_o, 1'b1);
      tick();
      bus.fetch_en_i     = 1'b0;
      bus.instr_rvalid_i = 1'b1;
      tick();
      bus.instr_rvalid_i = 1'b0;
      tick();
      chk_empty("err");

      // address wrap at the top of the space
      bus.redirect_i      = 1'b1;
      bus.redirect_addr_i = 32'hFFFF_FFFE;
      tick();
      bus.redirect_i = 1'b0;
      exp_both(32'hFFFF_FFFC);
      exp_both(32'h0);
      bus.fetch_en_i = 1'b1;
      auto_rsp       = 1'b1;
      tick();
      tick();
      bus.fetch_en_i = 1'b0;
      tick();
      tick();
      auto_rsp = 1'b0;
      chk_empty("wrap");

      // asynchronous reset with a transaction in flight
      exp_req.push_back(32'h4);
      bus.fetch_en_i = 1'b1;
      tick();
      bus.fetch_en_i = 1'b0;
      chk1("pre_rst_busy", bus.busy_o, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      chk1("rst_async_busy", bus.busy_o, 1'b0);
      chk1("rst_async_req", bus.instr_req_o, 1'b0);
      chk("rst_async_addr", bus.instr_addr_o, 32'h100);
      tick();
      rst = 1'b0;
      #1;
      chk1("rst_release_busy", bus.busy_o, 1'b0);
      chk("rst_release_addr", bus.instr_addr_o, 32'h100);
      chk_empty("rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
